// File: rtl/pe_vec_mac_pipe.sv
// pe_vec_mac_pipe: pipelined multi-lane signed fixed-point processing element.
// Each lane performs MUL, ADD, FMA or a streaming MAC reduction. Input and
// output use valid/ready handshakes. One global advance signal moves every
// register level together, so the output is held stable while downstream stalls.
// Register levels: S1 operand capture, S2 multiply/add, S3 accumulate, then the
// output register that saturates to W_IN.
// Optional feature macro: PE_VEC_RELU6_EN clamps flagged results to [0, 6.0].
module pe_vec_mac_pipe #(
    parameter int LANES     = 4,
    parameter int W_IN      = 8,
    parameter int FRAC_BITS = 4,
    parameter int W_ACC     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_op,
    input  logic                    in_last,
    input  logic                    in_relu,
    input  logic [LANES*W_IN-1:0]   in_a,
    input  logic [LANES*W_IN-1:0]   in_b,
    input  logic [LANES*W_IN-1:0]   in_c,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*W_IN-1:0]   out_r,
    output logic [LANES-1:0]        out_ovf
);

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_MAC = 2'b10;
    localparam logic [1:0] OP_FMA = 2'b11;

    // Working width for sums before clamping: wide enough for the full product
    // or an accumulator sum plus headroom, so nothing wraps before saturation.
    localparam int W_X = ((2 * W_IN > W_ACC) ? 2 * W_IN : W_ACC) + 2;

    // Saturate a W_X value to W_ACC; MSB of the result is the clamp flag.
    function automatic logic [W_ACC:0] sat_acc(input logic signed [W_X-1:0] v);
        logic signed [W_X-1:0] hi;
        logic signed [W_X-1:0] lo;
        hi = {{(W_X - W_ACC + 1){1'b0}}, {(W_ACC - 1){1'b1}}};
        lo = {{(W_X - W_ACC + 1){1'b1}}, {(W_ACC - 1){1'b0}}};
        if (v > hi)
            sat_acc = {1'b1, hi[W_ACC-1:0]};
        else if (v < lo)
            sat_acc = {1'b1, lo[W_ACC-1:0]};
        else
            sat_acc = {1'b0, v[W_ACC-1:0]};
    endfunction

    // Saturate a W_ACC value to W_IN; MSB of the result is the clamp flag.
    function automatic logic [W_IN:0] sat_in(input logic signed [W_ACC-1:0] v);
        logic signed [W_ACC-1:0] hi;
        logic signed [W_ACC-1:0] lo;
        hi = {{(W_ACC - W_IN + 1){1'b0}}, {(W_IN - 1){1'b1}}};
        lo = {{(W_ACC - W_IN + 1){1'b1}}, {(W_IN - 1){1'b0}}};
        if (v > hi)
            sat_in = {1'b1, hi[W_IN-1:0]};
        else if (v < lo)
            sat_in = {1'b1, lo[W_IN-1:0]};
        else
            sat_in = {1'b0, v[W_IN-1:0]};
    endfunction

    logic adv;

    logic                         s1_valid_reg;
    logic [1:0]                   s1_op_reg;
    logic                         s1_last_reg;
    logic [LANES*W_IN-1:0]        s1_a_reg;
    logic [LANES*W_IN-1:0]        s1_b_reg;
    logic [LANES*W_IN-1:0]        s1_c_reg;

    logic                         s2_valid_reg;
    logic [1:0]                   s2_op_reg;
    logic                         s2_last_reg;
    logic [LANES-1:0][W_ACC-1:0]  s2_val_reg;
    logic [LANES-1:0]             s2_ovf_reg;
    logic [LANES-1:0][W_ACC-1:0]  s2_val_next;
    logic [LANES-1:0]             s2_ovf_next;

    logic                         s3_valid_reg;
    logic [LANES-1:0][W_ACC-1:0]  s3_val_reg;
    logic [LANES-1:0]             s3_ovf_reg;

    logic [LANES-1:0][W_ACC-1:0]  acc_reg;
    logic [LANES-1:0]             acc_ovf_reg;
    logic                         mac_first_reg;
    logic [LANES-1:0][W_ACC-1:0]  mac_val_next;
    logic [LANES-1:0]             mac_ovf_next;

    logic [LANES*W_IN-1:0]        out_r_next;
    logic [LANES-1:0]             out_ovf_next;

    // Every level moves together whenever the output register is free to load.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

`ifdef PE_VEC_RELU6_EN
    localparam logic signed [W_IN-1:0] RELU_MAX = W_IN'(6 << FRAC_BITS);

    logic s1_relu_reg;
    logic s2_relu_reg;
    logic s3_relu_reg;

    // The ReLU request travels alongside its beat through every level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_relu_reg <= 1'b0;
            s2_relu_reg <= 1'b0;
            s3_relu_reg <= 1'b0;
        end else if (adv) begin
            s1_relu_reg <= in_relu;
            s2_relu_reg <= s1_relu_reg;
            s3_relu_reg <= s2_relu_reg;
        end
    end
`else
    // The port is kept for interface stability but has no function here.
    logic relu_unused;
    assign relu_unused = in_relu;
`endif

    // S1: capture the accepted beat's operands and control.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_op_reg    <= OP_MUL;
            s1_last_reg  <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_c_reg     <= '0;
        end else if (adv) begin
            s1_valid_reg <= in_valid;
            s1_op_reg    <= in_op;
            s1_last_reg  <= in_last;
            s1_a_reg     <= in_a;
            s1_b_reg     <= in_b;
            s1_c_reg     <= in_c;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [W_IN-1:0]           a_l;
            logic [W_IN-1:0]           b_l;
            logic [W_IN-1:0]           c_l;
            logic signed [2*W_IN-1:0]  a_x;
            logic signed [2*W_IN-1:0]  b_x;
            logic signed [2*W_IN-1:0]  prod_full;
            logic signed [2*W_IN-1:0]  prod_sh;
            logic [W_ACC:0]            prod_r;
            logic [W_ACC:0]            fma_r;
            logic [W_ACC-1:0]          add_v;
            logic [W_ACC-1:0]          base;
            logic                      base_ovf;
            logic [W_ACC:0]            mac_r;
            logic [W_IN:0]             fin_r;
            logic signed [W_IN-1:0]    res_sat;
            logic signed [W_IN-1:0]    res_fin;

            assign a_l = s1_a_reg[gi*W_IN +: W_IN];
            assign b_l = s1_b_reg[gi*W_IN +: W_IN];
            assign c_l = s1_c_reg[gi*W_IN +: W_IN];

            // Full-width signed product, rescaled to the Q format, then clamped.
            assign a_x       = {{W_IN{a_l[W_IN-1]}}, a_l};
            assign b_x       = {{W_IN{b_l[W_IN-1]}}, b_l};
            assign prod_full = a_x * b_x;
            assign prod_sh   = prod_full >>> FRAC_BITS;
            assign prod_r    = sat_acc({{(W_X - 2*W_IN){prod_sh[2*W_IN-1]}}, prod_sh});
            assign fma_r     = sat_acc({{(W_X - W_ACC){prod_r[W_ACC-1]}}, prod_r[W_ACC-1:0]}
                                     + {{(W_X - W_IN){c_l[W_IN-1]}}, c_l});
            assign add_v     = {{(W_ACC - W_IN){a_l[W_IN-1]}}, a_l}
                             + {{(W_ACC - W_IN){b_l[W_IN-1]}}, b_l};

            // MAC beats carry the clamped product forward; accumulation happens in S3.
            assign s2_val_next[gi] = (s1_op_reg == OP_ADD) ? add_v :
                                     (s1_op_reg == OP_FMA) ? fma_r[W_ACC-1:0] :
                                                             prod_r[W_ACC-1:0];
            assign s2_ovf_next[gi] = (s1_op_reg == OP_ADD) ? 1'b0 :
                                     (s1_op_reg == OP_FMA) ? (prod_r[W_ACC] | fma_r[W_ACC]) :
                                                             prod_r[W_ACC];

            // A new reduction starts from zero and forgets earlier clamp history.
            assign base     = mac_first_reg ? '0 : acc_reg[gi];
            assign base_ovf = !mac_first_reg && acc_ovf_reg[gi];
            assign mac_r    = sat_acc({{(W_X - W_ACC){base[W_ACC-1]}}, base}
                                    + {{(W_X - W_ACC){s2_val_reg[gi][W_ACC-1]}}, s2_val_reg[gi]});
            assign mac_val_next[gi] = mac_r[W_ACC-1:0];
            assign mac_ovf_next[gi] = s2_ovf_reg[gi] | base_ovf | mac_r[W_ACC];

            // Final narrowing to the lane width, then the optional ReLU6 bound.
            assign fin_r   = sat_in(s3_val_reg[gi]);
            assign res_sat = fin_r[W_IN-1:0];
`ifdef PE_VEC_RELU6_EN
            assign res_fin = !s3_relu_reg      ? res_sat :
                             res_sat[W_IN-1]   ? '0 :
                             (res_sat > RELU_MAX) ? RELU_MAX : res_sat;
`else
            assign res_fin = res_sat;
`endif
            assign out_r_next[gi*W_IN +: W_IN] = res_fin;
            assign out_ovf_next[gi]            = s3_ovf_reg[gi] | fin_r[W_IN];
        end
    endgenerate

    // S2: register the per-lane product or sum at accumulator width.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_op_reg    <= OP_MUL;
            s2_last_reg  <= 1'b0;
            s2_val_reg   <= '0;
            s2_ovf_reg   <= '0;
        end else if (adv) begin
            s2_valid_reg <= s1_valid_reg;
            s2_op_reg    <= s1_op_reg;
            s2_last_reg  <= s1_last_reg;
            s2_val_reg   <= s2_val_next;
            s2_ovf_reg   <= s2_ovf_next;
        end
    end

    // S3: fold MAC beats into the accumulator; only results that leave the
    // pipeline (non-MAC, or MAC with last) become valid here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s3_valid_reg  <= 1'b0;
            s3_val_reg    <= '0;
            s3_ovf_reg    <= '0;
            acc_reg       <= '0;
            acc_ovf_reg   <= '0;
            mac_first_reg <= 1'b1;
        end else if (adv) begin
            s3_valid_reg <= 1'b0;
            if (s2_valid_reg) begin
                if (s2_op_reg == OP_MAC) begin
                    acc_reg       <= mac_val_next;
                    acc_ovf_reg   <= mac_ovf_next;
                    mac_first_reg <= s2_last_reg;
                    s3_valid_reg  <= s2_last_reg;
                    s3_val_reg    <= mac_val_next;
                    s3_ovf_reg    <= mac_ovf_next;
                end else begin
                    s3_valid_reg  <= 1'b1;
                    s3_val_reg    <= s2_val_reg;
                    s3_ovf_reg    <= s2_ovf_reg;
                end
            end
        end
    end

    // Output register: holds its value until the downstream accepts it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_r     <= '0;
            out_ovf   <= '0;
        end else if (adv) begin
            out_valid <= s3_valid_reg;
            if (s3_valid_reg) begin
                out_r   <= out_r_next;
                out_ovf <= out_ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_pe_vec_mac_pipe.sv
// Testbench for pe_vec_mac_pipe: directed cases plus randomized traffic with
// random downstream back-pressure, checked against an integer reference model.
module tb_pe_vec_mac_pipe;

    localparam int LANES     = 4;
    localparam int W_IN      = 8;
    localparam int FRAC_BITS = 4;
    localparam int W_ACC     = 16;
    localparam int W         = LANES * W_IN;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic           in_valid  = 1'b0;
    logic           in_ready;
    logic [1:0]     in_op     = 2'b00;
    logic           in_last   = 1'b0;
    logic           in_relu   = 1'b0;
    logic [W-1:0]   in_a      = '0;
    logic [W-1:0]   in_b      = '0;
    logic [W-1:0]   in_c      = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   out_r;
    logic [LANES-1:0] out_ovf;

    always #5 clk = ~clk;

    pe_vec_mac_pipe #(
        .LANES(LANES), .W_IN(W_IN), .FRAC_BITS(FRAC_BITS), .W_ACC(W_ACC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_last(in_last), .in_relu(in_relu),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_ovf(out_ovf)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [W-1:0]     r;
        logic [LANES-1:0] ovf;
        logic             relu;
    } exp_t;

    exp_t exp_q[$];
    int   acc_m[LANES];
    bit   acc_ovf_m[LANES];
    bit   first_m = 1'b1;

    function automatic int clampi(input int v, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < LANES; i++) begin
            acc_m[i]     = 0;
            acc_ovf_m[i] = 1'b0;
        end
        first_m = 1'b1;
        exp_q.delete();
    endfunction

    function automatic void model_accept(input logic [1:0] op, input logic last, input logic relu,
                                         input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c);
        exp_t e;
        int av, bv, cv, p_raw, p, v, base, y;
        bit po, vo, bo;
        e.r = '0;
        e.ovf = '0;
        e.relu = relu;
        for (int i = 0; i < LANES; i++) begin
            av = $signed(a[i*W_IN +: W_IN]);
            bv = $signed(b[i*W_IN +: W_IN]);
            cv = $signed(c[i*W_IN +: W_IN]);
            p_raw = (av * bv) >>> FRAC_BITS;
            p  = clampi(p_raw, W_ACC);
            po = (p != p_raw);
            case (op)
                2'b00: begin v = p; vo = po; end
                2'b01: begin v = av + bv; vo = 1'b0; end
                2'b11: begin v = clampi(p + cv, W_ACC); vo = po | (v != p + cv); end
                default: begin
                    base = first_m ? 0 : acc_m[i];
                    bo   = first_m ? 1'b0 : acc_ovf_m[i];
                    v    = clampi(base + p, W_ACC);
                    vo   = po | bo | (v != base + p);
                    acc_m[i]     = v;
                    acc_ovf_m[i] = vo;
                end
            endcase
            y = clampi(v, W_IN);
            e.ovf[i] = vo | (y != v);
`ifdef PE_VEC_RELU6_EN
            if (relu)
                y = (y < 0) ? 0 : ((y > (6 << FRAC_BITS)) ? (6 << FRAC_BITS) : y);
`endif
            e.r[i*W_IN +: W_IN] = y[W_IN-1:0];
        end
        if (op == 2'b10)
            first_m = last;
        if (op != 2'b10 || last)
            exp_q.push_back(e);
    endfunction

    // ---------------- monitor ----------------
    int               out_count    = 0;
    int               stall_cycles = 0;
    logic [W-1:0]     last_r       = '0;
    logic [LANES-1:0] last_ovf     = '0;
    logic [W-1:0]     prev_r       = '0;
    logic [LANES-1:0] prev_ovf     = '0;
    bit               prev_stall   = 1'b0;
    bit               rst_edge_seen = 1'b0;

    always @(posedge clk) rst_edge_seen <= !rst_n;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                if (rst_edge_seen)
                    check_val("rst_out_valid", out_valid, 1'b0);
                model_reset();
                prev_stall = 1'b0;
            end else begin
                check_val("in_ready", in_ready, !out_valid || out_ready);
                if (prev_stall) begin
                    check_val("stall_valid", out_valid, 1'b1);
                    check_val("stall_r", out_r, prev_r);
                    check_val("stall_ovf", out_ovf, prev_ovf);
                end
                if (in_valid && in_ready)
                    model_accept(in_op, in_last, in_relu, in_a, in_b, in_c);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_val("extra_out", out_valid, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("out_r", out_r, e.r);
                        check_val("out_ovf", out_ovf, e.ovf);
                        $display("out %0d r=%h ovf=%b relu=%0d", out_count, out_r, out_ovf, e.relu);
                    end
                    out_count++;
                    last_r   = out_r;
                    last_ovf = out_ovf;
                end
                if (out_valid && !out_ready)
                    stall_cycles++;
                prev_stall = out_valid && !out_ready;
                prev_r     = out_r;
                prev_ovf   = out_ovf;
            end
        end
    end

    // ---------------- downstream ready ----------------
    int stall_pct = 0;
    bit force_low = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = force_low ? 1'b0 : ($urandom_range(99) >= stall_pct);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic last, input logic relu,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        bit accepted;
        int t;
        accepted = 1'b0;
        t = 0;
        in_op = op; in_last = last; in_relu = relu;
        in_a = a; in_b = b; in_c = c;
        in_valid = 1'b1;
        while (!accepted) begin
            @(negedge clk);
            accepted = in_ready;
            tick();
            t++;
            if (!accepted && t > 100) begin
                check_val("in_timeout", accepted, 1'b1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_outputs(input int n);
        int t;
        t = 0;
        while (out_count < n && t < 100) begin
            tick();
            t++;
        end
        check_val("out_arrived", out_count >= n, 1'b1);
    endtask

    task automatic run_one(input string tag, input logic [1:0] op, input logic relu,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_r, input logic [LANES-1:0] exp_ovf);
        int n0;
        n0 = out_count;
        send(op, 1'b1, relu, a, b, '0);
        wait_outputs(n0 + 1);
        check_val({tag, "_r"}, last_r, exp_r);
        check_val({tag, "_ovf"}, last_ovf, exp_ovf);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n0;
        int s0;
        logic [1:0] op;
        logic last;

        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_val("reset_in_ready", in_ready, 1'b1);
        check_val("reset_out_valid", out_valid, 1'b0);
        check_val("reset_out_r", out_r, '0);
        check_val("reset_out_ovf", out_ovf, '0);
        tick();

        // MUL 2.0 * 1.5 with exact three-cycle latency
        send(2'b00, 1'b0, 1'b0, {LANES{8'h20}}, {LANES{8'h18}}, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("latency_valid", out_valid, (i == 3));
        end
        tick();
        check_val("mul_r", last_r, {LANES{8'h30}});
        check_val("mul_ovf", last_ovf, '0);

        // Four-beat MAC reduction, then a fresh one-beat reduction
        n0 = out_count;
        for (int i = 0; i < 4; i++)
            send(2'b10, (i == 3), 1'b0, {LANES{8'h10}}, {LANES{8'h10}}, '0);
        wait_outputs(n0 + 1);
        repeat (4) tick();
        check_val("mac_bubbles", out_count, n0 + 1);
        check_val("mac4_r", last_r, {LANES{8'h40}});
        check_val("mac4_ovf", last_ovf, '0);
        run_one("mac1", 2'b10, 1'b0, {LANES{8'h20}}, {LANES{8'h10}}, {LANES{8'h20}}, '0);

        // Saturation boundaries
        run_one("mul_pos_sat", 2'b00, 1'b0, {LANES{8'h7F}}, {LANES{8'h7F}}, {LANES{8'h7F}}, '1);
        run_one("mul_neg_sat", 2'b00, 1'b0, {LANES{8'h80}}, {LANES{8'h7F}}, {LANES{8'h80}}, '1);
        run_one("add_sat", 2'b01, 1'b0, {LANES{8'h70}}, {LANES{8'h20}}, {LANES{8'h7F}}, '1);

        // Eight ADD beats with a five-cycle downstream stall in the middle
        n0 = out_count;
        s0 = stall_cycles;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(2'b01, 1'b0, 1'b0, W'($urandom), W'($urandom), '0);
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                force_low = 1'b1;
                repeat (5) @(posedge clk);
                @(negedge clk);
                force_low = 1'b0;
            end
        join
        tick();
        wait_outputs(n0 + 8);
        repeat (3) tick();
        check_val("stream_count", out_count, n0 + 8);
        check_val("stall_seen", (stall_cycles - s0) >= 5, 1'b1);

        // Reset in the middle of a reduction discards the partial sum
        n0 = out_count;
        send(2'b10, 1'b0, 1'b0, {LANES{8'h30}}, {LANES{8'h20}}, '0);
        send(2'b10, 1'b0, 1'b0, {LANES{8'h30}}, {LANES{8'h20}}, '0);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_in_ready", in_ready, 1'b1);
        tick();
        run_one("mac_after_rst", 2'b10, 1'b0, {LANES{8'h10}}, {LANES{8'h10}}, {LANES{8'h10}}, '0);
        check_val("rst_drop_count", out_count, n0 + 1);

        // ReLU6 request
`ifdef PE_VEC_RELU6_EN
        run_one("relu_neg", 2'b01, 1'b1, {LANES{8'hD0}}, '0, '0, '0);
        run_one("relu_hi", 2'b01, 1'b1, {LANES{8'h70}}, '0, {LANES{8'h60}}, '0);
`else
        run_one("relu_neg", 2'b01, 1'b1, {LANES{8'hD0}}, '0, {LANES{8'hD0}}, '0);
        run_one("relu_hi", 2'b01, 1'b1, {LANES{8'h70}}, '0, {LANES{8'h70}}, '0);
`endif

        // Randomized traffic with random back-pressure
        stall_pct = 30;
        for (int k = 0; k < 300; k++) begin
            op   = 2'($urandom_range(3));
            last = (op == 2'b10) ? ($urandom_range(3) == 0) : 1'($urandom_range(1));
            send(op, last, 1'($urandom_range(1)), W'($urandom), W'($urandom), W'($urandom));
            if ($urandom_range(3) == 0)
                tick();
        end
        stall_pct = 0;
        for (int t = 0; t < 200 && exp_q.size() != 0; t++)
            tick();
        repeat (4) tick();
        check_val("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
